mul_csv_arb: RTL and testbench
==============================

MUL_CSV_ARB -- requirements
Module: mul_csv_arb

Interface
REQ-001 SHALL have parameter numReq, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter widthX, default 8, width of XS/XC multiplier operands (widthX <= widthY).
REQ-003 SHALL have parameter widthY, default 8, width of multiplicand Y.
REQ-004 SHALL have parameter speed, default 2, passed unchanged to the internal carry-save multiplier.
REQ-005 SHALL have parameter stages, default 2, number of result pipeline registers (1..4).
REQ-006 SHALL have port clk_i, input, 1, the only clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid_i, input, numReq, per-requester operand valid.
REQ-009 SHALL have port req_ready_o, output, numReq, per-requester accept.
REQ-010 SHALL have port req_xs_i, input, numReq*widthX, XS operands; requester k at bits [k*widthX +: widthX].
REQ-011 SHALL have port req_xc_i, input, numReq*widthX, XC operands; same packing.
REQ-012 SHALL have port req_y_i, input, numReq*widthY, Y operands; requester k at bits [k*widthY +: widthY].
REQ-013 SHALL have port res_valid_o, output, 1, result valid.
REQ-014 SHALL have port res_ready_i, input, 1, result consumer ready.
REQ-015 SHALL have port res_ps_o, output, widthX+widthY, product sum vector.
REQ-016 SHALL have port res_pc_o, output, widthX+widthY, product carry vector.
REQ-017 SHALL have port res_id_o, output, clog2(numReq) (min 1), index of the originating requester.
REQ-018 SHALL have port res_ovf_o, output, 1, set when XS+XC overflowed widthX bits.
REQ-019 SHALL have port busy_o, output, 1, high while any pipeline stage holds a valid entry.

Function
REQ-020 SHALL instantiate one shared carry-save unsigned multiplier (XS, XC, Y -> PS, PC), fed combinationally from the granted requester's operands.
REQ-021 SHALL grant at most one requester per cycle by round-robin: search starts at pointer rr; the first k with req_valid_i[k]=1 in order rr, rr+1, ... wraps modulo numReq.
REQ-022 SHALL define stall = res_valid_o & ~res_ready_i; req_ready_o[k] = grant[k] & ~stall; all other ready bits 0.
REQ-023 SHALL accept requester k only when req_valid_i[k] & req_ready_o[k]; rr then becomes (k+1) mod numReq on the next edge; otherwise rr holds.
REQ-024 SHALL load stage 1 with {valid=accept, PS, PC, id=k, ovf=carry-out of XS+XC} when not stalled; on a non-accepting, non-stalled cycle stage 1 valid becomes 0.
REQ-025 SHALL advance every stage by one per non-stalled cycle and freeze all stages (valid and data) while stalled; bubbles are not collapsed.
REQ-026 SHALL drive res_* from stage stages; latency from accept edge to res_valid_o=1 is exactly stages cycles when no stall occurs.
REQ-027 SHALL sustain one accepted request per cycle when res_ready_i is held high.
REQ-028 SHALL guarantee res_ps_o + res_pc_o mod 2^(widthX+widthY) = ((XS+XC) mod 2^widthX) * Y whenever res_ovf_o=0; the individual PS/PC bit patterns are not specified.
REQ-029 SHALL keep res_ps_o, res_pc_o, res_id_o, res_ovf_o stable while res_valid_o=1 and res_ready_i=0.
REQ-030 SHALL not depend on req_valid_i deassertion rules: a requester may drop valid without handshake; the grant then moves on the same cycle.
REQ-031 SHALL drive busy_o = OR of all stage valid bits.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously clear all stage valid bits, rr to 0, and all stage data registers to 0; hence res_valid_o=0, res_ps_o=0, res_pc_o=0, res_id_o=0, res_ovf_o=0, busy_o=0.
REQ-033 SHALL discard in-flight results when reset asserts mid-operation; first grant after release is to requester 0 if valid.
REQ-034 SHALL drive req_ready_o=0 during reset.

Verification
REQ-035 Single request: requester 2 only, XS=3, XC=4, Y=10, res_ready_i=1 -> res_valid_o after 2 cycles (stages=2), PS+PC=70, res_id_o=2, res_ovf_o=0.
REQ-036 Round-robin: all 4 requesters valid continuously, res_ready_i=1 -> accepts in order 0,1,2,3,0,... one per cycle; res_id_o sequence 0,1,2,3.
REQ-037 Backpressure: stream from requester 1, res_ready_i=0 for 5 cycles after first result -> outputs stable, all req_ready_o=0, no loss or duplication after release.
REQ-038 Overflow: XS=200, XC=100, Y=5 -> res_ovf_o=1; XS=255, XC=0, Y=255 -> PS+PC=65025, res_ovf_o=0.
REQ-039 Mid-operation reset: assert rst_ni low with 2 entries in flight -> res_valid_o=0 and busy_o=0 immediately; after release, requesters 3 and 0 valid -> requester 0 granted first.
REQ-040 Random: random valid/ready/operands for 10^5 cycles vs. scoreboard per requester -> every accepted request produces exactly one in-order result with correct sum and id.

Source files
------------

// File: rtl/mul_csv_arb.sv
// mul_csv_arb: round-robin arbiter feeding one shared carry-save multiplier
// through a stallable result pipeline.
module mul_csv #(
  parameter int widthX = 8,
  parameter int widthY = 8,
  parameter int speed  = 2
) (
  input  logic [widthX-1:0]        i_xs,
  input  logic [widthX-1:0]        i_xc,
  input  logic [widthY-1:0]        i_y,
  output logic [widthX+widthY-1:0] o_ps,
  output logic [widthX+widthY-1:0] o_pc
);
  localparam int PW = widthX + widthY;
  // Fast form keeps XS*Y and XC*Y as the two redundant vectors and skips the adder.
  if (speed >= 2) begin : g_fast
    assign o_ps = PW'(i_xs) * PW'(i_y);
    assign o_pc = PW'(i_xc) * PW'(i_y);
  end else begin : g_small
    logic [widthX-1:0] w_x;
    assign w_x  = i_xs + i_xc;
    assign o_ps = PW'(w_x) * PW'(i_y);
    assign o_pc = '0;
  end
endmodule

module mul_csv_arb #(
  parameter int numReq = 4,
  parameter int widthX = 8,
  parameter int widthY = 8,
  parameter int speed  = 2,
  parameter int stages = 2,
  localparam int IW = (numReq > 1) ? $clog2(numReq) : 1,
  localparam int PW = widthX + widthY
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [numReq-1:0]        req_valid_i,
  output logic [numReq-1:0]        req_ready_o,
  input  logic [numReq*widthX-1:0] req_xs_i,
  input  logic [numReq*widthX-1:0] req_xc_i,
  input  logic [numReq*widthY-1:0] req_y_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [PW-1:0]            res_ps_o,
  output logic [PW-1:0]            res_pc_o,
  output logic [IW-1:0]            res_id_o,
  output logic                     res_ovf_o,
  output logic                     busy_o
);
  logic [IW-1:0]     r_rr;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_j;
  logic [numReq-1:0] w_grant;
  logic              w_stall;
  logic              w_acc;
  logic              w_ovf;
  logic [widthX-1:0] w_xs;
  logic [widthX-1:0] w_xc;
  logic [widthY-1:0] w_y;
  logic [PW-1:0]     w_ps;
  logic [PW-1:0]     w_pc;
  logic              r_vld [stages];
  logic [PW-1:0]     r_ps  [stages];
  logic [PW-1:0]     r_pc  [stages];
  logic [IW-1:0]     r_id  [stages];
  logic              r_ovf [stages];
  // Scan from the far end so the requester nearest to r_rr overwrites the rest.
  always_comb begin
    w_idx = '0;
    w_j   = '0;
    for (int i = numReq - 1; i >= 0; i--) begin
      w_j = IW'((int'(r_rr) + i) % numReq);
      if (req_valid_i[w_j]) w_idx = w_j;
    end
  end
  assign w_grant     = req_valid_i[w_idx] ? (numReq'(1) << w_idx) : '0;
  assign w_stall     = res_valid_o & ~res_ready_i;
  assign req_ready_o = w_grant & {numReq{~w_stall & rst_ni}};
  assign w_acc       = |req_ready_o;
  assign w_xs        = req_xs_i[w_idx*widthX +: widthX];
  assign w_xc        = req_xc_i[w_idx*widthX +: widthX];
  assign w_y         = req_y_i[w_idx*widthY +: widthY];
  assign w_ovf       = widthX'(w_xs + w_xc) < w_xs;
  mul_csv #(.widthX(widthX), .widthY(widthY), .speed(speed)) u_mul (
    .i_xs(w_xs), .i_xc(w_xc), .i_y(w_y), .o_ps(w_ps), .o_pc(w_pc)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
      for (int s = 0; s < stages; s++) begin
        r_vld[s] <= 1'b0;
        r_ps[s]  <= '0;
        r_pc[s]  <= '0;
        r_id[s]  <= '0;
        r_ovf[s] <= 1'b0;
      end
    end else if (!w_stall) begin
      if (w_acc) r_rr <= (w_idx == IW'(numReq - 1)) ? '0 : w_idx + 1'b1;
      r_vld[0] <= w_acc;
      r_ps[0]  <= w_ps;
      r_pc[0]  <= w_pc;
      r_id[0]  <= w_idx;
      r_ovf[0] <= w_ovf;
      for (int s = 1; s < stages; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_ps[s]  <= r_ps[s-1];
        r_pc[s]  <= r_pc[s-1];
        r_id[s]  <= r_id[s-1];
        r_ovf[s] <= r_ovf[s-1];
      end
    end
  end
  always_comb begin
    busy_o = 1'b0;
    for (int s = 0; s < stages; s++) busy_o = busy_o | r_vld[s];
  end
  assign res_valid_o = r_vld[stages-1];
  assign res_ps_o    = r_ps[stages-1];
  assign res_pc_o    = r_pc[stages-1];
  assign res_id_o    = r_id[stages-1];
  assign res_ovf_o   = r_ovf[stages-1];
endmodule

// File: tb/tb_mul_csv_arb.sv
// tb_mul_csv_arb: directed scenario tasks plus a short scoreboarded random run.
module tb_mul_csv_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  vld = '0;
  logic [3:0]  rq_ready;
  logic [31:0] xs_v = '0, xc_v = '0, y_v = '0;
  logic        res_valid, rdy_in = 1'b1, res_ovf, busy;
  logic [15:0] res_ps, res_pc;
  logic [1:0]  res_id;
  int total = 0, bad = 0;

  mul_csv_arb dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld), .req_ready_o(rq_ready),
    .req_xs_i(xs_v), .req_xc_i(xc_v), .req_y_i(y_v), .res_valid_o(res_valid),
    .res_ready_i(rdy_in), .res_ps_o(res_ps), .res_pc_o(res_pc), .res_id_o(res_id),
    .res_ovf_o(res_ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input int xs, input int xc, input int y);
    xs_v[k*8 +: 8] = 8'(xs);
    xc_v[k*8 +: 8] = 8'(xc);
    y_v[k*8 +: 8]  = 8'(y);
  endtask

  task automatic do_reset();
    vld = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_one(input int k, input int xs, input int xc, input int y);
    set_op(k, xs, xc, y);
    vld = 4'(1 << k);
    tick();
    vld = '0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = 4'b1111;
    #3;
    total++; if (rq_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b want=0000", rq_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", res_valid); end
    total++; if (res_ps !== 16'd0 || res_pc !== 16'd0) begin bad++; $display("FAIL rst_data got=%0d/%0d want=0/0", res_ps, res_pc); end
    total++; if (res_id !== 2'd0 || res_ovf !== 1'b0) begin bad++; $display("FAIL rst_id_ovf got=%0d/%b want=0/0", res_id, res_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    tick();
    vld = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] s;
    rdy_in = 1'b1;
    set_op(2, 3, 4, 10);
    vld = 4'b0100;
    #1;
    total++; if (rq_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", rq_ready); end
    tick();
    vld = '0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_lat1 got=%b/%b want=0/1", res_valid, busy); end
    tick();
    s = res_ps + res_pc;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", res_valid); end
    total++; if (s !== 16'd70) begin bad++; $display("FAIL single_sum got=%0d want=70", s); end
    total++; if (res_id !== 2'd2 || res_ovf !== 1'b0) begin bad++; $display("FAIL single_id_ovf got=%0d/%b want=2/0", res_id, res_ovf); end
    tick();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_drain got=%b/%b want=0/0", res_valid, busy); end
  endtask

  task automatic test_round_robin();
    int exp_rr [4] = '{5, 24, 49, 80};
    logic [15:0] s;
    do_reset();
    for (int k = 0; k < 4; k++) set_op(k, k + 1, 2 * k, k + 5);
    rdy_in = 1'b1;
    vld = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) vld = '0;
      #1;
      if (c < 8) begin
        total++; if (rq_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, rq_ready, 4'(1 << (c % 4))); end
      end
      tick();
      if (c >= 1 && c <= 8) begin
        s = res_ps + res_pc;
        total++; if (res_valid !== 1'b1 || res_id !== 2'((c - 1) % 4)) begin bad++; $display("FAIL rr_id c=%0d got=%b/%0d want=1/%0d", c, res_valid, res_id, (c - 1) % 4); end
        total++; if (s !== 16'(exp_rr[(c - 1) % 4])) begin bad++; $display("FAIL rr_sum c=%0d got=%0d want=%0d", c, s, exp_rr[(c - 1) % 4]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_sent = 0, n_got = 0;
    logic acc;
    logic [15:0] s, snap_ps = '0, snap_pc = '0;
    logic [1:0] snap_id = '0;
    do_reset();
    set_op(1, 1, 1, 3);
    vld = 4'b0010;
    rdy_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (n_sent == 6) vld = '0;
      if (c == 3) rdy_in = 1'b0;
      if (c == 8) rdy_in = 1'b1;
      #1;
      acc = vld[1] & rq_ready[1];
      if (c == 3) begin snap_ps = res_ps; snap_pc = res_pc; snap_id = res_id; end
      if (c >= 3 && c < 8) begin
        total++; if (rq_ready !== 4'b0 || res_valid !== 1'b1) begin bad++; $display("FAIL bp_stall c=%0d got=%b/%b want=0000/1", c, rq_ready, res_valid); end
        total++; if (res_ps !== snap_ps || res_pc !== snap_pc || res_id !== snap_id) begin bad++; $display("FAIL bp_stable c=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", c, res_ps, res_pc, res_id, snap_ps, snap_pc, snap_id); end
      end
      if (res_valid && rdy_in) begin
        s = res_ps + res_pc;
        total++; if (s !== 16'((n_got + 2) * 3) || res_id !== 2'd1) begin bad++; $display("FAIL bp_data n=%0d got=%0d/%0d want=%0d/1", n_got, s, res_id, (n_got + 2) * 3); end
        n_got++;
      end
      tick();
      if (acc) begin n_sent++; set_op(1, n_sent + 1, 1, 3); end
    end
    total++; if (n_got !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", n_got); end
  endtask

  task automatic test_overflow();
    logic [15:0] s;
    do_reset();
    rdy_in = 1'b1;
    run_one(0, 200, 100, 5);
    total++; if (res_valid !== 1'b1 || res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b/%b want=1/1", res_valid, res_ovf); end
    run_one(0, 255, 0, 255);
    s = res_ps + res_pc;
    total++; if (res_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", res_ovf); end
    total++; if (s !== 16'd65025) begin bad++; $display("FAIL ovf_max got=%0d want=65025", s); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    rdy_in = 1'b1;
    set_op(2, 1, 1, 1);
    vld = 4'b0100;
    tick();
    tick();
    vld = '0;
    total++; if (res_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mr_inflight got=%b/%b want=1/1", res_valid, busy); end
    rst_n = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_clear got=%b/%b want=0/0", res_valid, busy); end
    tick();
    rst_n = 1'b1;
    set_op(3, 2, 2, 2);
    set_op(0, 3, 0, 7);
    vld = 4'b1001;
    #1;
    total++; if (rq_ready !== 4'b0001) begin bad++; $display("FAIL mr_first got=%b want=0001", rq_ready); end
    tick();
    #1;
    total++; if (rq_ready !== 4'b1000) begin bad++; $display("FAIL mr_second got=%b want=1000", rq_ready); end
    vld = '0;
    tick();
    total++; if (res_valid !== 1'b1 || res_id !== 2'd0 || 16'(res_ps + res_pc) !== 16'd21) begin bad++; $display("FAIL mr_result got=%b/%0d/%0d want=1/0/21", res_valid, res_id, 16'(res_ps + res_pc)); end
    tick();
    tick();
  endtask

  typedef struct { logic [1:0] id; logic [15:0] sum; logic ovf; } exp_t;

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    int a;
    logic [15:0] s;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c < 3980) begin
        vld = 4'($urandom);
        xs_v = $urandom; xc_v = $urandom; y_v = $urandom;
        rdy_in = ($urandom % 4) != 0;
      end else begin
        vld = '0;
        rdy_in = 1'b1;
      end
      #1;
      if ($countones(rq_ready) > 1 || (rq_ready & ~vld) != 0) begin
        total++; bad++; $display("FAIL rnd_ready c=%0d got=%b valid=%b", c, rq_ready, vld);
      end
      if (res_valid && rdy_in) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_extra c=%0d got=id%0d want=none", c, res_id);
        end else begin
          e = q.pop_front();
          s = res_ps + res_pc;
          if (res_id !== e.id || res_ovf !== e.ovf || (!e.ovf && s !== e.sum)) begin
            bad++; $display("FAIL rnd_data c=%0d got=%0d/%b/%0d want=%0d/%b/%0d", c, res_id, res_ovf, s, e.id, e.ovf, e.sum);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (vld[k] && rq_ready[k]) begin
          a = xs_v[k*8 +: 8] + xc_v[k*8 +: 8];
          e.id = 2'(k);
          e.ovf = a > 255;
          e.sum = 16'((a & 255) * y_v[k*8 +: 8]);
          q.push_back(e);
        end
      end
      tick();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got=%0d want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
